lsu_mem_access: RTL and testbench
=================================

// Module: lsu_mem_access
// PURPOSE
//  Load/store stage directly downstream of the execute stage. Takes exc_alu_out as the effective address (or as the result
//  for non-memory ops), rs2_data as store data, and mem_op. Runs a valid/ready bus transaction to data memory.
//  Aligns, masks and sign/zero-extends load data. Hands one result per instruction to writeback.
// PARAMETERS
//  XLEN       64  datapath and address width; bus data width equals XLEN
//  MEMOP_LEN  4   mem_op width. Encoding: 0 NONE, 1 LB, 2 LH, 3 LW, 4 LD, 5 LBU, 6 LHU, 7 LWU, 8 SB, 9 SH, 10 SW, 11 SD; 12-15 are treated as NONE
//  REGW       5   rd index width
// PORTS
//  clk          in   1          clock, all state updates on rising edge
//  rst          in   1          synchronous reset, active high
//  in_valid     in   1          execute result valid
//  in_ready     out  1          stage can accept a new instruction
//  in_alu_out   in   XLEN       exc_alu_out: address for load/store, result otherwise
//  in_rs2_data  in   XLEN       store data
//  in_rd_idx    in   REGW       destination register
//  in_mem_op    in   MEMOP_LEN  memory op code
//  bus_req      out  1          memory request valid
//  bus_gnt      in   1          memory accepts request (req&&gnt = handshake)
//  bus_we       out  1          1 store, 0 load
//  bus_addr     out  XLEN       address aligned down to 8 bytes
//  bus_wdata    out  XLEN       store data shifted to byte lane
//  bus_wmask    out  8          byte strobe
//  bus_rvalid   in   1          response beat (loads and stores both get one)
//  bus_rdata    in   XLEN       load data, full 8-byte word
//  wb_valid     out  1          result valid to writeback
//  wb_ready     in   1          writeback accepts (wb_valid&&wb_ready)
//  wb_rd_idx    out  REGW       destination register
//  wb_data      out  XLEN       result data
//  wb_wen       out  1          1 for loads and non-memory ops, 0 for stores
// BEHAVIOUR
//  - FSM states: IDLE, REQ, WAIT, DONE. Reset -> IDLE. All outputs are 0 in reset, except in_ready=1.
//  - IDLE: in_ready=1. On in_valid, capture all inputs.
//    - NONE op -> DONE with wb_data=in_alu_out; 1-cycle latency.
//    - Load/store -> REQ.
//  - REQ: bus_req=1 and bus outputs held stable until bus_gnt. Handshake -> WAIT. bus_req drops the following cycle.
//  - WAIT: on bus_rvalid, a load formats and registers wb_data -> DONE. bus_rvalid in REQ or IDLE is ignored.
//  - DONE: wb_valid=1 and wb_* stable until wb_ready. Handshake -> IDLE. in_ready=0 in REQ/WAIT/DONE; no bypass.
//  - Minimum load latency is in_valid to wb_valid = 3 cycles (gnt and rvalid each in the first possible cycle).
//  - Byte lane is off=addr[2:0]. bus_wmask:
//    - SB: 1<<off
//    - SH: 3<<off
//    - SW: 0xF<<off
//    - SD: 0xFF
//  - bus_wdata = rs2_data << (8*off).
//  - Load: shifted = rdata >> (8*off), then take the low 8/16/32/64 bits. LB/LH/LW sign-extend; LBU/LHU/LWU zero-extend.
//  - Misaligned handling is governed by CONFIGURATION. Without the macro, the access is not split and bits beyond the 8-byte word are lost.
//  - rst mid-transaction: the FSM returns to IDLE next cycle and bus_req drops. A pending bus_rvalid after reset is ignored.
// CONFIGURATION
//  LSU_MISALIGN_CHECK_EN defined:
//    - Adds output fault (1b) and fault_addr (XLEN).
//    - H requires addr[0]=0, W requires addr[1:0]=0, D requires addr[2:0]=0. Violation skips REQ and goes to DONE with fault=1, fault_addr=addr, wb_wen=0.
//    - fault clears on the wb handshake.
//  Not defined: no fault ports; misaligned accesses are issued per the lane rules above.
// TESTING
//  - Reset: hold rst 2 cycles -> in_ready=1, bus_req=0, wb_valid=0.
//  - NONE op, alu_out=0x1234, rd=5, wb_ready=1 -> wb_valid on the next cycle, wb_data=0x1234, wb_wen=1, bus_req never asserted.
//  - SB addr=0x1003, rs2=0xAB -> bus_we=1, bus_addr=0x1000, bus_wmask=0x08, bus_wdata=0xAB000000. Hold gnt=0 for 3 cycles: request stays stable. wb_wen=0.
//  - LB addr=0x2006, rdata=0x0080_0000_0000_0000 -> wb_data=0xFFFF_FFFF_FFFF_FF80. LBU at the same address -> 0x80.
//  - LW addr=0x2004, rdata=0x8000_0001_0000_0000 -> wb_data=0xFFFF_FFFF_8000_0001. LWU -> 0x8000_0001. Hold wb_ready=0 2 cycles -> data stable, in_ready=0.
//  - Assert rst during WAIT -> IDLE next cycle, later bus_rvalid yields no wb_valid. With LSU_MISALIGN_CHECK_EN, LW at 0x2002 -> fault=1, no bus_req.

Source files
------------

// File: rtl/lsu_mem_access.sv
// Load/store stage: turns an execute result into at most one data-memory
// transaction and hands exactly one result per instruction to writeback.
//
// Ports
//   clk, rst               clock, synchronous active-high reset
//   in_*                   instruction from execute (valid/ready)
//   bus_*                  data-memory request (req/gnt) and response (rvalid/rdata)
//   wb_*                   result to writeback (valid/ready)
//   fault, fault_addr      misalignment report (only with LSU_MISALIGN_CHECK_EN)
//
// Optional feature macro: LSU_MISALIGN_CHECK_EN
//   When defined, misaligned H/W/D accesses skip the bus and complete with
//   fault=1.
//   When undefined, misaligned accesses are issued within one 8-byte word,
//   and any bytes beyond that word are dropped.
module lsu_mem_access #(
  parameter int unsigned XLEN      = 64,
  parameter int unsigned MEMOP_LEN = 4,
  parameter int unsigned REGW      = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [XLEN-1:0]      in_alu_out,
  input  logic [XLEN-1:0]      in_rs2_data,
  input  logic [REGW-1:0]      in_rd_idx,
  input  logic [MEMOP_LEN-1:0] in_mem_op,
  output logic                 bus_req,
  input  logic                 bus_gnt,
  output logic                 bus_we,
  output logic [XLEN-1:0]      bus_addr,
  output logic [XLEN-1:0]      bus_wdata,
  output logic [7:0]           bus_wmask,
  input  logic                 bus_rvalid,
  input  logic [XLEN-1:0]      bus_rdata,
  output logic                 wb_valid,
  input  logic                 wb_ready,
  output logic [REGW-1:0]      wb_rd_idx,
  output logic [XLEN-1:0]      wb_data,
  output logic                 wb_wen
`ifdef LSU_MISALIGN_CHECK_EN
  ,
  output logic                 fault,
  output logic [XLEN-1:0]      fault_addr
`endif
);

  localparam int unsigned OFFW  = 3;
  localparam int unsigned MASKW = 8;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  state_t state, state_nxt;

  // Decoded view of the incoming op
  logic            in_is_load, in_is_store, in_unsigned;
  logic [1:0]      in_size;
  logic [OFFW-1:0] in_off;
  logic            in_mis;

  // Captured load formatting controls
  logic            is_load_q, unsigned_q;
  logic [1:0]      size_q;
  logic [OFFW-1:0] off_q;

  logic [XLEN-1:0] load_shifted, load_fmt;

  assign in_off = in_alu_out[OFFW-1:0];

  // Op decode: size 0=B 1=H 2=W 3=D; codes 12-15 fall through as NONE
  always_comb begin
    in_is_load  = 1'b0;
    in_is_store = 1'b0;
    in_unsigned = 1'b0;
    in_size     = 2'd0;
    case (in_mem_op)
      MEMOP_LEN'(1):  begin in_is_load  = 1'b1; in_size = 2'd0; end
      MEMOP_LEN'(2):  begin in_is_load  = 1'b1; in_size = 2'd1; end
      MEMOP_LEN'(3):  begin in_is_load  = 1'b1; in_size = 2'd2; end
      MEMOP_LEN'(4):  begin in_is_load  = 1'b1; in_size = 2'd3; end
      MEMOP_LEN'(5):  begin in_is_load  = 1'b1; in_size = 2'd0; in_unsigned = 1'b1; end
      MEMOP_LEN'(6):  begin in_is_load  = 1'b1; in_size = 2'd1; in_unsigned = 1'b1; end
      MEMOP_LEN'(7):  begin in_is_load  = 1'b1; in_size = 2'd2; in_unsigned = 1'b1; end
      MEMOP_LEN'(8):  begin in_is_store = 1'b1; in_size = 2'd0; end
      MEMOP_LEN'(9):  begin in_is_store = 1'b1; in_size = 2'd1; end
      MEMOP_LEN'(10): begin in_is_store = 1'b1; in_size = 2'd2; end
      MEMOP_LEN'(11): begin in_is_store = 1'b1; in_size = 2'd3; end
      default: ;
    endcase
  end

`ifdef LSU_MISALIGN_CHECK_EN
  // Natural alignment check for H/W/D memory ops
  always_comb begin
    in_mis = 1'b0;
    if (in_is_load || in_is_store) begin
      case (in_size)
        2'd1:    in_mis = in_off[0];
        2'd2:    in_mis = |in_off[1:0];
        2'd3:    in_mis = |in_off;
        default: in_mis = 1'b0;
      endcase
    end
  end
`else
  assign in_mis = 1'b0;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (in_valid) begin
              if (!(in_is_load || in_is_store) || in_mis) state_nxt = DONE;
              else                                        state_nxt = REQ;
            end
      REQ:  if (bus_gnt)    state_nxt = WAIT;
      WAIT: if (bus_rvalid) state_nxt = DONE;
      DONE: if (wb_ready)   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Align and extend the returned word
  always_comb begin
    load_shifted = bus_rdata >> {off_q, 3'b000};
    load_fmt     = load_shifted;
    case (size_q)
      2'd0: load_fmt = unsigned_q ? XLEN'(load_shifted[7:0])
                                  : {{(XLEN-8){load_shifted[7]}}, load_shifted[7:0]};
      2'd1: load_fmt = unsigned_q ? XLEN'(load_shifted[15:0])
                                  : {{(XLEN-16){load_shifted[15]}}, load_shifted[15:0]};
      2'd2: load_fmt = unsigned_q ? XLEN'(load_shifted[31:0])
                                  : {{(XLEN-32){load_shifted[31]}}, load_shifted[31:0]};
      default: load_fmt = load_shifted;
    endcase
  end

  // Registered outputs follow the next state; datapath captured in IDLE
  always_ff @(posedge clk) begin
    if (rst) begin
      in_ready   <= 1'b1;
      bus_req    <= 1'b0;
      bus_we     <= 1'b0;
      bus_addr   <= '0;
      bus_wdata  <= '0;
      bus_wmask  <= '0;
      wb_valid   <= 1'b0;
      wb_rd_idx  <= '0;
      wb_data    <= '0;
      wb_wen     <= 1'b0;
      is_load_q  <= 1'b0;
      unsigned_q <= 1'b0;
      size_q     <= 2'd0;
      off_q      <= '0;
`ifdef LSU_MISALIGN_CHECK_EN
      fault      <= 1'b0;
      fault_addr <= '0;
`endif
    end else begin
      in_ready <= (state_nxt == IDLE);
      bus_req  <= (state_nxt == REQ);
      wb_valid <= (state_nxt == DONE);

      if (state == IDLE && in_valid) begin
        bus_we     <= in_is_store;
        bus_addr   <= {in_alu_out[XLEN-1:OFFW], OFFW'(0)};
        bus_wdata  <= in_rs2_data << {in_off, 3'b000};
        case (in_size)
          2'd0:    bus_wmask <= MASKW'(8'h01 << in_off);
          2'd1:    bus_wmask <= MASKW'(8'h03 << in_off);
          2'd2:    bus_wmask <= MASKW'(8'h0F << in_off);
          default: bus_wmask <= MASKW'(8'hFF);
        endcase
        wb_rd_idx  <= in_rd_idx;
        wb_data    <= (in_is_load || in_is_store) ? '0 : in_alu_out;
        wb_wen     <= !in_is_store && !in_mis;
        is_load_q  <= in_is_load;
        unsigned_q <= in_unsigned;
        size_q     <= in_size;
        off_q      <= in_off;
`ifdef LSU_MISALIGN_CHECK_EN
        fault      <= in_mis;
        fault_addr <= in_mis ? in_alu_out : '0;
`endif
      end

      if (state == WAIT && bus_rvalid && is_load_q) wb_data <= load_fmt;

`ifdef LSU_MISALIGN_CHECK_EN
      if (state == DONE && wb_ready) fault <= 1'b0;
`endif
    end
  end

endmodule

// File: tb/tb_lsu_mem_access.sv
// Directed bench for lsu_mem_access: reset, pass-through, stores, loads,
// backpressure on both sides and reset during an outstanding load.
module tb_lsu_mem_access;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_alu_out;
  logic [63:0] in_rs2_data;
  logic [4:0]  in_rd_idx;
  logic [3:0]  in_mem_op;
  logic        bus_req;
  logic        bus_gnt;
  logic        bus_we;
  logic [63:0] bus_addr;
  logic [63:0] bus_wdata;
  logic [7:0]  bus_wmask;
  logic        bus_rvalid;
  logic [63:0] bus_rdata;
  logic        wb_valid;
  logic        wb_ready;
  logic [4:0]  wb_rd_idx;
  logic [63:0] wb_data;
  logic        wb_wen;
`ifdef LSU_MISALIGN_CHECK_EN
  logic        fault;
  logic [63:0] fault_addr;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  lsu_mem_access dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_alu_out(in_alu_out), .in_rs2_data(in_rs2_data),
    .in_rd_idx(in_rd_idx), .in_mem_op(in_mem_op),
    .bus_req(bus_req), .bus_gnt(bus_gnt), .bus_we(bus_we),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_wmask(bus_wmask),
    .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_rd_idx(wb_rd_idx),
    .wb_data(wb_data), .wb_wen(wb_wen)
`ifdef LSU_MISALIGN_CHECK_EN
    , .fault(fault), .fault_addr(fault_addr)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Load with gnt and rvalid in the earliest cycle, then hold wb_ready low
  task automatic do_load(input string tag, input logic [3:0] op, input logic [63:0] addr,
                         input logic [63:0] rdata, input logic [63:0] exp, input int hold);
    wb_ready   = 1'b0;
    in_valid   = 1'b1;
    in_mem_op  = op;
    in_alu_out = addr;
    in_rd_idx  = 5'd9;
    step();
    in_valid = 1'b0;
    chk({tag, "_req"}, 64'(bus_req), 64'd1);
    chk({tag, "_we"},  64'(bus_we),  64'd0);
    chk({tag, "_addr"}, bus_addr, {addr[63:3], 3'b000});
    bus_gnt = 1'b1;
    step();
    bus_gnt = 1'b0;
    chk({tag, "_req_drop"}, 64'(bus_req), 64'd0);
    chk({tag, "_no_wb_early"}, 64'(wb_valid), 64'd0);
    bus_rvalid = 1'b1;
    bus_rdata  = rdata;
    step();
    bus_rvalid = 1'b0;
    bus_rdata  = 64'hDEAD_DEAD_DEAD_DEAD;
    chk({tag, "_wb_valid"}, 64'(wb_valid), 64'd1);
    chk({tag, "_wb_data"},  wb_data, exp);
    chk({tag, "_wb_wen"},   64'(wb_wen), 64'd1);
    chk({tag, "_wb_rd"},    64'(wb_rd_idx), 64'd9);
    for (int i = 0; i < hold; i++) begin
      step();
      chk({tag, "_hold_valid"}, 64'(wb_valid), 64'd1);
      chk({tag, "_hold_data"},  wb_data, exp);
      chk({tag, "_hold_ready"}, 64'(in_ready), 64'd0);
    end
    wb_ready = 1'b1;
    step();
    chk({tag, "_wb_done"}, 64'(wb_valid), 64'd0);
    chk({tag, "_ready_back"}, 64'(in_ready), 64'd1);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_alu_out = '0; in_rs2_data = '0;
    in_rd_idx = '0; in_mem_op = '0; bus_gnt = 1'b0; bus_rvalid = 1'b0;
    bus_rdata = '0; wb_ready = 1'b0;

    // Reset
    step(); step();
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_bus_req",  64'(bus_req),  64'd0);
    chk("rst_wb_valid", 64'(wb_valid), 64'd0);
    rst = 1'b0;
    step();
    chk("idle_in_ready", 64'(in_ready), 64'd1);

    // NONE pass-through, one-cycle latency
    wb_ready = 1'b1; in_valid = 1'b1; in_mem_op = 4'd0;
    in_alu_out = 64'h1234; in_rd_idx = 5'd5;
    step();
    in_valid = 1'b0;
    chk("none_wb_valid", 64'(wb_valid), 64'd1);
    chk("none_wb_data",  wb_data, 64'h1234);
    chk("none_wb_wen",   64'(wb_wen), 64'd1);
    chk("none_wb_rd",    64'(wb_rd_idx), 64'd5);
    chk("none_no_req",   64'(bus_req), 64'd0);
    chk("none_busy",     64'(in_ready), 64'd0);
    step();
    chk("none_done",     64'(wb_valid), 64'd0);
    chk("none_idle",     64'(in_ready), 64'd1);

    // Reserved op code behaves as NONE
    in_valid = 1'b1; in_mem_op = 4'd13; in_alu_out = 64'h55; in_rd_idx = 5'd3;
    step();
    in_valid = 1'b0;
    chk("rsvd_wb_data", wb_data, 64'h55);
    chk("rsvd_no_req",  64'(bus_req), 64'd0);
    step();

    // SB with grant held off three cycles
    in_valid = 1'b1; in_mem_op = 4'd8; in_alu_out = 64'h1003;
    in_rs2_data = 64'hAB; in_rd_idx = 5'd1;
    step();
    in_valid = 1'b0; in_rs2_data = 64'hFFFF; in_alu_out = 64'h0;
    for (int i = 0; i < 4; i++) begin
      chk("sb_req",   64'(bus_req), 64'd1);
      chk("sb_we",    64'(bus_we),  64'd1);
      chk("sb_addr",  bus_addr,  64'h1000);
      chk("sb_mask",  64'(bus_wmask), 64'h08);
      chk("sb_wdata", bus_wdata, 64'hAB00_0000);
      if (i < 3) step();
    end
    bus_gnt = 1'b1;
    step();
    bus_gnt = 1'b0;
    chk("sb_req_drop", 64'(bus_req), 64'd0);
    bus_rvalid = 1'b1;
    step();
    bus_rvalid = 1'b0;
    chk("sb_wb_valid", 64'(wb_valid), 64'd1);
    chk("sb_wb_wen",   64'(wb_wen), 64'd0);
    step();
    chk("sb_done", 64'(wb_valid), 64'd0);

    // SH at lane 6 and SD full word: mask and lane shift
    in_valid = 1'b1; in_mem_op = 4'd9; in_alu_out = 64'h1006; in_rs2_data = 64'h1234;
    step();
    in_valid = 1'b0;
    chk("sh_mask",  64'(bus_wmask), 64'hC0);
    chk("sh_wdata", bus_wdata, 64'h1234_0000_0000_0000);
    bus_gnt = 1'b1; step(); bus_gnt = 1'b0;
    bus_rvalid = 1'b1; step(); bus_rvalid = 1'b0;
    step();
    in_valid = 1'b1; in_mem_op = 4'd11; in_alu_out = 64'h1008;
    in_rs2_data = 64'h0123_4567_89AB_CDEF;
    step();
    in_valid = 1'b0;
    chk("sd_mask",  64'(bus_wmask), 64'hFF);
    chk("sd_wdata", bus_wdata, 64'h0123_4567_89AB_CDEF);
    chk("sd_addr",  bus_addr, 64'h1008);
    bus_gnt = 1'b1; step(); bus_gnt = 1'b0;
    bus_rvalid = 1'b1; step(); bus_rvalid = 1'b0;
    step();

    // Loads: sign/zero extension and lane selection
    do_load("lb",  4'd1, 64'h2006, 64'h0080_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FF80, 0);
    do_load("lbu", 4'd5, 64'h2006, 64'h0080_0000_0000_0000, 64'h0000_0000_0000_0080, 0);
    do_load("lw",  4'd3, 64'h2004, 64'h8000_0001_0000_0000, 64'hFFFF_FFFF_8000_0001, 2);
    do_load("lwu", 4'd7, 64'h2004, 64'h8000_0001_0000_0000, 64'h0000_0000_8000_0001, 0);
    do_load("lh",  4'd2, 64'h2002, 64'h0000_0000_8765_0000, 64'hFFFF_FFFF_FFFF_8765, 0);
    do_load("lhu", 4'd6, 64'h2002, 64'h0000_0000_8765_0000, 64'h0000_0000_0000_8765, 0);
    do_load("ld",  4'd4, 64'h2000, 64'hDEAD_BEEF_CAFE_F00D, 64'hDEAD_BEEF_CAFE_F00D, 0);

    // Reset while a load waits for its response
    wb_ready = 1'b1; in_valid = 1'b1; in_mem_op = 4'd4; in_alu_out = 64'h3000;
    step();
    in_valid = 1'b0;
    bus_gnt = 1'b1; step(); bus_gnt = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rstw_req",   64'(bus_req),  64'd0);
    chk("rstw_ready", 64'(in_ready), 64'd1);
    chk("rstw_wb",    64'(wb_valid), 64'd0);
    bus_rvalid = 1'b1; bus_rdata = 64'h1111;
    step();
    bus_rvalid = 1'b0;
    chk("rstw_stale_wb",    64'(wb_valid), 64'd0);
    chk("rstw_stale_ready", 64'(in_ready), 64'd1);
    step();
    chk("rstw_stale_wb2", 64'(wb_valid), 64'd0);

`ifdef LSU_MISALIGN_CHECK_EN
    // Misaligned LW completes with a fault and never reaches the bus
    wb_ready = 1'b0; in_valid = 1'b1; in_mem_op = 4'd3; in_alu_out = 64'h2002;
    step();
    in_valid = 1'b0;
    chk("mis_wb_valid", 64'(wb_valid), 64'd1);
    chk("mis_fault",    64'(fault), 64'd1);
    chk("mis_addr",     fault_addr, 64'h2002);
    chk("mis_wen",      64'(wb_wen), 64'd0);
    chk("mis_no_req",   64'(bus_req), 64'd0);
    wb_ready = 1'b1;
    step();
    chk("mis_fault_clr", 64'(fault), 64'd0);
    chk("mis_no_req2",   64'(bus_req), 64'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
